mack_bus_controller: RTL and testbench
======================================

Name: mack_bus_controller

Overview:
- Bus-cycle sequencer for the 68000 bus. Sits between the address decoder's active-low chip selects and the CPU's DTACK/BERR/VPA inputs.
- Generates DTACK with a per-device wait-state count. For MFP cycles it forwards the MFP's own DTACK_IN.
- Asserts VPA for autovectored interrupt acknowledges. Asserts BERR when nothing answers.
- Keeps a saturating bus-error count for debug.

Parameters:
- ROM_WAIT, 2, wait states for ROM cycles (0..15)
- RAM_WAIT, 0, wait states for RAM cycles (0..15)
- DUART_WAIT, 3, wait states for DUART cycles (0..15)
- AVEC_WAIT, 8, cycles an IACK cycle waits for DTACK_IN before VPA (1..255)
- TIMEOUT, 64, cycles without acknowledge before BERR (AVEC_WAIT < TIMEOUT <= 1023)

Ports:
- CLK  in  1  system clock, same as CPU clock
- RST  in  1  asynchronous reset, active-low
- AS  in  1  CPU address strobe, active-low
- IACK  in  1  interrupt-acknowledge decode, active-low
- ROMEN  in  1  ROM select, active-low
- RAMEN  in  1  RAM select, active-low
- MFPEN  in  1  MFP select, active-low
- DUARTEN  in  1  DUART select, active-low
- DTACK_IN  in  1  DTACK from MFP, active-low
- DTACK  out  1  to CPU, active-low, registered
- BERR  out  1  to CPU, active-low, registered
- VPA  out  1  to CPU, active-low, registered
- BERR_COUNT  out  8  saturating count of BERR cycles

Behaviour:
- Reset (RST=0, async, takes effect immediately):
  - DTACK=1, BERR=1, VPA=1.
  - BERR_COUNT=0, state=IDLE, counter=0.
  - Reset during a bus cycle negates all outputs at once.
- All inputs are sampled on the rising CLK edge. No synchronizers: everything is on the CPU clock domain.
- States: IDLE, WAIT, EXT, ACK, VEC, FAULT, DONE.
- IDLE: on AS sampled 0, classify the cycle by priority:
  - IACK=0: go to EXT with iack flag set.
  - MFPEN=0: go to EXT.
  - DUARTEN=0: go to WAIT, counter=DUART_WAIT.
  - ROMEN=0: go to WAIT, counter=ROM_WAIT.
  - RAMEN=0: go to WAIT, counter=RAM_WAIT.
  - No select active: go to EXT, no device. This path can only time out.
  - EXT entry loads counter=0.
- WAIT: if counter==0, go to ACK. Otherwise decrement.
  - DTACK falls N+1 cycles after the edge that sampled AS low, where N is the wait count.
  - With N=0, DTACK is low at the next edge.
- EXT: counter increments each cycle. Evaluate in this order:
  1. DTACK_IN=0 and the cycle is MFP or iack: go to ACK. This has priority over any limit reached on the same edge.
  2. iack and counter==AVEC_WAIT-1: go to VEC.
  3. counter==TIMEOUT-1: go to FAULT.
- ACK: DTACK=0. VEC: VPA=0. FAULT: BERR=0.
  - FAULT entry increments BERR_COUNT, saturating at 255.
  - Each of ACK, VEC and FAULT holds its output until AS is sampled 1, then goes to DONE with all outputs returned to 1 on that edge.
- DONE: go to IDLE on the next edge.
  - Guarantees one full cycle between strobes.
  - A new cycle is never accepted while AS is still low from the previous one.
- AS sampled 1 while in WAIT or EXT (aborted cycle): go to IDLE. No output is asserted and BERR_COUNT is unchanged.
- Outputs are mutually exclusive: at most one of DTACK, BERR, VPA is low in any cycle.
- Counter width is clog2(TIMEOUT+1). Wait parameters are truncated to 4 bits.
- Chip-select changes after classification are ignored until DONE.

Test Plan:
- ROM read, ROM_WAIT=2: AS low sampled at edge 0 with ROMEN=0 and RAMEN=0 -> DTACK low from edge 3 until the edge after AS high; the ROM path is taken, not the RAM path.
- RAM read, RAM_WAIT=0, back-to-back AS strobes -> DTACK low at edge 1 of each cycle; the second cycle is only classified after DONE.
- MFP cycle with DTACK_IN low at cycle 5 -> DTACK low at cycle 6. MFP never answering -> BERR low at cycle 64, BERR_COUNT goes 0->1.
- IACK cycle, no DTACK_IN -> VPA low at cycle 8 (AVEC_WAIT=8), BERR never asserted. A repeat with DTACK_IN low at cycle 8 -> DTACK wins and VPA stays high.
- Unmapped access (no selects) -> BERR at TIMEOUT. Repeat 300 times -> BERR_COUNT saturates at 255.
- Abort and reset: AS high in WAIT at cycle 1 -> no DTACK, IDLE. RST low while DTACK is low -> DTACK=1 immediately, BERR_COUNT=0.

Source files
------------

// File: rtl/mack_bus_controller.sv
// mack_bus_controller
// Bus-cycle sequencer for a 68000 bus. It watches the address strobe and the
// decoder's active-low chip selects. It answers each cycle with DTACK after a
// per-device wait count, forwards the MFP's own DTACK, and raises VPA for
// autovectored interrupt acknowledges. If nothing answers, it raises BERR.
// A saturating count of bus errors is kept for debug.
//
// Ports (all active-low except CLK and BERR_COUNT):
//   CLK        system clock, the same clock as the CPU
//   RST        asynchronous reset
//   AS         CPU address strobe
//   IACK       interrupt-acknowledge decode
//   ROMEN      ROM select
//   RAMEN      RAM select
//   MFPEN      MFP select
//   DUARTEN    DUART select
//   DTACK_IN   DTACK from the MFP
//   DTACK      to the CPU, registered
//   BERR       to the CPU, registered
//   VPA        to the CPU, registered
//   BERR_COUNT saturating count of BERR cycles
//
// state  | meaning
// IDLE   | waiting for AS low; the cycle is classified here
// WAIT   | counting down the wait states of a fixed-latency device
// EXT    | counting up while waiting for DTACK_IN, autovector or timeout
// ACK    | DTACK low until AS goes high
// VEC    | VPA low until AS goes high
// FAULT  | BERR low until AS goes high
// DONE   | one dead cycle before the next strobe is accepted

module mack_bus_controller #(
    parameter int ROM_WAIT   = 2,
    parameter int RAM_WAIT   = 0,
    parameter int DUART_WAIT = 3,
    parameter int AVEC_WAIT  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       IACK,
    input  logic       ROMEN,
    input  logic       RAMEN,
    input  logic       MFPEN,
    input  logic       DUARTEN,
    input  logic       DTACK_IN,
    output logic       DTACK,
    output logic       BERR,
    output logic       VPA,
    output logic [7:0] BERR_COUNT
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Wait counts are 4-bit quantities; higher parameter bits are dropped.
    localparam logic [CNT_W-1:0] ROM_LOAD   = CNT_W'(4'(ROM_WAIT));
    localparam logic [CNT_W-1:0] RAM_LOAD   = CNT_W'(4'(RAM_WAIT));
    localparam logic [CNT_W-1:0] DUART_LOAD = CNT_W'(4'(DUART_WAIT));
    localparam logic [CNT_W-1:0] AVEC_LAST  = CNT_W'(AVEC_WAIT - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_EXT,
        S_ACK,
        S_VEC,
        S_FAULT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             iack_q, iack_d;
    logic             mfp_q, mfp_d;
    logic [7:0]       berr_count_q, berr_count_d;
    logic             dtack_q, berr_q, vpa_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        iack_d       = iack_q;
        mfp_d        = mfp_q;
        berr_count_d = berr_count_q;

        case (state_q)
            S_IDLE: begin
                if (!AS) begin
                    iack_d = 1'b0;
                    mfp_d  = 1'b0;
                    cnt_d  = '0;
                    if (!IACK) begin
                        state_d = S_EXT;
                        iack_d  = 1'b1;
                    end else if (!MFPEN) begin
                        state_d = S_EXT;
                        mfp_d   = 1'b1;
                    end else if (!DUARTEN) begin
                        state_d = S_WAIT;
                        cnt_d   = DUART_LOAD;
                    end else if (!ROMEN) begin
                        state_d = S_WAIT;
                        cnt_d   = ROM_LOAD;
                    end else if (!RAMEN) begin
                        state_d = S_WAIT;
                        cnt_d   = RAM_LOAD;
                    end else begin
                        // Unmapped access: can only end in a timeout.
                        state_d = S_EXT;
                    end
                end
            end
            S_WAIT: begin
                if (AS) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_EXT: begin
                if (AS) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A device acknowledge beats a limit reached on the same edge.
                    if (!DTACK_IN && (iack_q || mfp_q)) begin
                        state_d = S_ACK;
                    end else if (iack_q && (cnt_q == AVEC_LAST)) begin
                        state_d = S_VEC;
                    end else if (cnt_q == TOUT_LAST) begin
                        state_d = S_FAULT;
                        if (berr_count_q != 8'hFF) begin
                            berr_count_d = berr_count_q + 8'd1;
                        end
                    end
                end
            end
            S_ACK, S_VEC, S_FAULT: begin
                if (AS) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            iack_q       <= 1'b0;
            mfp_q        <= 1'b0;
            berr_count_q <= 8'd0;
            dtack_q      <= 1'b1;
            berr_q       <= 1'b1;
            vpa_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            iack_q       <= iack_d;
            mfp_q        <= mfp_d;
            berr_count_q <= berr_count_d;
            // Outputs decode the next state so they change on the entry edge.
            dtack_q      <= (state_d != S_ACK);
            berr_q       <= (state_d != S_FAULT);
            vpa_q        <= (state_d != S_VEC);
        end
    end

    assign DTACK      = dtack_q;
    assign BERR       = berr_q;
    assign VPA        = vpa_q;
    assign BERR_COUNT = berr_count_q;

endmodule

// File: tb/tb_mack_bus_controller.sv
module tb_mack_bus_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       as_n, iack_n, romen, ramen, mfpen, duarten, dtack_in;
    logic       dtack, berr, vpa;
    logic [7:0] berr_count;

    int checks = 0;
    int errors = 0;

    mack_bus_controller dut (
        .CLK        (clk),
        .RST        (rst),
        .AS         (as_n),
        .IACK       (iack_n),
        .ROMEN      (romen),
        .RAMEN      (ramen),
        .MFPEN      (mfpen),
        .DUARTEN    (duarten),
        .DTACK_IN   (dtack_in),
        .DTACK      (dtack),
        .BERR       (berr),
        .VPA        (vpa),
        .BERR_COUNT (berr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        as_n = 1'b1; iack_n = 1'b1; romen = 1'b1; ramen = 1'b1;
        mfpen = 1'b1; duarten = 1'b1; dtack_in = 1'b1;
    endtask

    initial begin
        idle_bus();
        rst = 1'b0;
        #12;
        check("reset_dtack", {7'd0, dtack}, 8'd1);
        check("reset_berr",  {7'd0, berr},  8'd1);
        check("reset_vpa",   {7'd0, vpa},   8'd1);
        check("reset_count", berr_count,    8'd0);
        rst = 1'b1;
        tick();

        // ROM read with RAM also selected: ROM has priority, 2 wait states.
        as_n = 1'b0; romen = 1'b0; ramen = 1'b0;
        tick();                                   // edge 0
        tick();                                   // edge 1
        check("rom_e1_dtack", {7'd0, dtack}, 8'd1);
        tick();                                   // edge 2
        check("rom_e2_dtack", {7'd0, dtack}, 8'd1);
        tick();                                   // edge 3
        check("rom_e3_dtack", {7'd0, dtack}, 8'd0);
        tick();                                   // held while AS low
        check("rom_hold_dtack", {7'd0, dtack}, 8'd0);
        idle_bus();
        tick();                                   // DONE
        check("rom_done_dtack", {7'd0, dtack}, 8'd1);
        tick();                                   // IDLE

        // RAM read, zero waits, back-to-back strobes.
        as_n = 1'b0; ramen = 1'b0;
        tick();                                   // edge 0
        tick();                                   // edge 1
        check("ram1_e1_dtack", {7'd0, dtack}, 8'd0);
        as_n = 1'b1;
        tick();                                   // DONE
        check("ram1_done_dtack", {7'd0, dtack}, 8'd1);
        as_n = 1'b0;
        tick();                                   // DONE -> IDLE, not classified
        check("ram2_idle_dtack", {7'd0, dtack}, 8'd1);
        tick();                                   // edge 0 of cycle 2
        check("ram2_e0_dtack", {7'd0, dtack}, 8'd1);
        tick();                                   // edge 1 of cycle 2
        check("ram2_e1_dtack", {7'd0, dtack}, 8'd0);
        idle_bus();
        tick();
        tick();

        // MFP answers during cycle 5, sampled at edge 6.
        as_n = 1'b0; mfpen = 1'b0;
        tick();                                   // edge 0
        repeat (5) tick();                        // edges 1..5
        check("mfp_e5_dtack", {7'd0, dtack}, 8'd1);
        dtack_in = 1'b0;
        tick();                                   // edge 6
        check("mfp_e6_dtack", {7'd0, dtack}, 8'd0);
        check("mfp_e6_berr",  {7'd0, berr},  8'd1);
        idle_bus();
        tick();
        check("mfp_done_dtack", {7'd0, dtack}, 8'd1);
        tick();

        // MFP never answers: BERR at edge 64.
        as_n = 1'b0; mfpen = 1'b0;
        tick();                                   // edge 0
        repeat (63) tick();                       // edges 1..63
        check("mfpto_e63_berr",  {7'd0, berr}, 8'd1);
        check("mfpto_e63_count", berr_count,   8'd0);
        tick();                                   // edge 64
        check("mfpto_e64_berr",  {7'd0, berr}, 8'd0);
        check("mfpto_e64_count", berr_count,   8'd1);
        idle_bus();
        tick();
        check("mfpto_done_berr", {7'd0, berr}, 8'd1);
        tick();

        // IACK, no DTACK_IN: VPA at edge 8, no BERR even when held long.
        as_n = 1'b0; iack_n = 1'b0;
        tick();                                   // edge 0
        repeat (7) tick();                        // edges 1..7
        check("iack_e7_vpa", {7'd0, vpa}, 8'd1);
        tick();                                   // edge 8
        check("iack_e8_vpa",   {7'd0, vpa},   8'd0);
        check("iack_e8_dtack", {7'd0, dtack}, 8'd1);
        repeat (70) tick();
        check("iack_hold_vpa",  {7'd0, vpa},  8'd0);
        check("iack_hold_berr", {7'd0, berr}, 8'd1);
        check("iack_count",     berr_count,   8'd1);
        idle_bus();
        tick();
        check("iack_done_vpa", {7'd0, vpa}, 8'd1);
        tick();

        // IACK with DTACK_IN sampled low at edge 8: DTACK wins over VPA.
        as_n = 1'b0; iack_n = 1'b0;
        tick();                                   // edge 0
        repeat (7) tick();                        // edges 1..7
        dtack_in = 1'b0;
        tick();                                   // edge 8
        check("iackd_e8_dtack", {7'd0, dtack}, 8'd0);
        check("iackd_e8_vpa",   {7'd0, vpa},   8'd1);
        idle_bus();
        tick();
        tick();

        // Unmapped access times out.
        as_n = 1'b0;
        tick();                                   // edge 0
        repeat (63) tick();
        check("unmap_e63_berr", {7'd0, berr}, 8'd1);
        tick();                                   // edge 64
        check("unmap_e64_berr",  {7'd0, berr}, 8'd0);
        check("unmap_e64_count", berr_count,   8'd2);
        idle_bus();
        tick();
        tick();

        // 300 more timeouts: the count must stop at 255, not wrap.
        for (int i = 0; i < 300; i++) begin
            as_n = 1'b0;
            tick();
            repeat (64) tick();
            as_n = 1'b1;
            tick();
            tick();
        end
        check("sat_count", berr_count, 8'd255);

        // Abort: AS high sampled at edge 1 of a ROM cycle.
        as_n = 1'b0; romen = 1'b0;
        tick();                                   // edge 0
        idle_bus();
        tick();                                   // edge 1, aborted
        check("abort_e1_dtack", {7'd0, dtack}, 8'd1);
        tick();
        check("abort_e2_dtack", {7'd0, dtack}, 8'd1);
        tick();
        check("abort_e3_dtack", {7'd0, dtack}, 8'd1);
        tick();
        check("abort_e4_dtack", {7'd0, dtack}, 8'd1);
        check("abort_count",    berr_count,    8'd255);

        // Reset while DTACK is low takes effect without a clock edge.
        as_n = 1'b0; ramen = 1'b0;
        tick();                                   // edge 0
        tick();                                   // edge 1
        check("rst_pre_dtack", {7'd0, dtack}, 8'd0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_dtack", {7'd0, dtack}, 8'd1);
        check("rst_async_count", berr_count,    8'd0);
        #2;
        idle_bus();
        rst = 1'b1;
        tick();
        check("rst_after_dtack", {7'd0, dtack}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
